// File: rtl/uart_pkg.sv
// Shared definitions for the UART word/byte path: data widths, the byte
// splitter FSM encoding and a byte-ordering helper.
package uart_pkg;

  localparam int unsigned ByteW = 8;
  localparam int unsigned WordW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StAck1,
    StDone1,
    StAck2,
    StDone2
  } tx_state_e;

  // Returns {first byte on the wire, second byte on the wire}.
  function automatic logic [WordW-1:0] order_bytes(input logic [WordW-1:0] word,
                                                   input bit               msb_first);
    return msb_first ? word : {word[ByteW-1:0], word[WordW-1:ByteW]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO with show-ahead read data.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset, flushes contents
//   push_i    : write wdata_i (ignored when full)
//   wdata_i   : write data
//   pop_i     : drop head entry (ignored when empty)
//   rdata_o   : head entry, valid when !empty_o
//   full_o    : level == DEPTH
//   empty_o   : level == 0
//   level_o   : entries currently stored
//   level_d_o : level after the current edge (for registered status flags)
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic [$clog2(DEPTH+1)-1:0] level_d_o
);

  localparam int unsigned LvlW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LvlW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // DEPTH is a power of two, so pointer overflow gives the modulo wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign level_o   = level_q;
  assign level_d_o = level_d;

endmodule

// File: rtl/uart_split_16bit.sv
// Buffers 16-bit words and feeds them as two bytes to a byte-wide UART
// transmitter using its tx_start/tx_busy handshake, with retry on a missing
// busy acknowledge.
//   clk              : clock
//   rst              : synchronous active-high reset
//   data_16bit       : word to transmit
//   data_16bit_valid : word present
//   data_16bit_ready : word can be accepted this cycle (0 in reset)
//   tx_data          : byte to uart_tx, held until the next tx_start
//   tx_start         : one-cycle start pulse to uart_tx
//   tx_busy          : uart_tx transmitting
//   fifo_level       : words buffered
//   idle             : FIFO empty and FSM idle (registered)
//   ack_error        : sticky, set when tx_busy failed to rise in time
module uart_split_16bit
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WordW-1:0]                data_16bit,
  input  logic                            data_16bit_valid,
  output logic                            data_16bit_ready,
  output logic [ByteW-1:0]                tx_data,
  output logic                            tx_start,
  input  logic                            tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            idle,
  output logic                            ack_error
);

  localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

  logic [WordW-1:0] fifo_rdata, ordered;
  logic             fifo_full, fifo_empty, push, pop, start_word;
  logic [LvlW-1:0]  level_nxt;

  tx_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [ByteW-1:0] byte2_q, byte2_d;
  logic [ByteW-1:0] tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             ack_error_q, ack_error_d;
  logic             idle_q, idle_d;

  // Ready deliberately ignores a same-cycle pop: a full FIFO always refuses.
  assign data_16bit_ready = !rst && !fifo_full;
  assign push             = data_16bit_valid && data_16bit_ready;

  sync_fifo #(
    .WIDTH(WordW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk),
    .rst_i    (rst),
    .push_i   (push),
    .wdata_i  (data_16bit),
    .pop_i    (pop),
    .rdata_o  (fifo_rdata),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .level_o  (fifo_level),
    .level_d_o(level_nxt)
  );

  assign ordered    = order_bytes(fifo_rdata, MSB_FIRST);
  // A new word may start from IDLE or straight out of DONE2.
  assign start_word = ((state_q == StIdle) || (state_q == StDone2)) && !tx_busy && !fifo_empty;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte2_d     = byte2_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    ack_error_d = ack_error_q;
    pop         = 1'b0;

    case (state_q)
      StAck1, StAck2: begin
        if (tx_busy) begin
          state_d = (state_q == StAck1) ? StDone1 : StDone2;
        end else if (cnt_q >= CntW'(ACK_TIMEOUT)) begin
          // Byte never acknowledged: flag it and pulse again with tx_data unchanged.
          ack_error_d = 1'b1;
          tx_start_d  = 1'b1;
          cnt_d       = CntW'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone1: begin
        if (!tx_busy) begin
          tx_data_d  = byte2_q;
          tx_start_d = 1'b1;
          cnt_d      = CntW'(1);
          state_d    = StAck2;
        end
      end
      StDone2: begin
        if (!tx_busy && fifo_empty) state_d = StIdle;
      end
      default: state_d = state_q;
    endcase

    if (start_word) begin
      pop        = 1'b1;
      tx_data_d  = ordered[WordW-1:ByteW];
      byte2_d    = ordered[ByteW-1:0];
      tx_start_d = 1'b1;
      cnt_d      = CntW'(1);
      state_d    = StAck1;
    end

    idle_d = (level_nxt == '0) && (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      byte2_q     <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      ack_error_q <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte2_q     <= byte2_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      ack_error_q <= ack_error_d;
      idle_q      <= idle_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign ack_error = ack_error_q;
  assign idle      = idle_q;

endmodule

// File: tb/tb_uart_split_16bit.sv
module tb_uart_split_16bit;

  localparam int Depth = 4;
  localparam int AckTo = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT 0: MSB first
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic [2:0]  level;
  logic        idle, ack_error;

  // DUT 1: LSB first
  logic [15:0] b_data;
  logic        b_valid;
  logic        b_ready;
  logic [7:0]  b_tx_data;
  logic        b_tx_start;
  logic        b_busy;
  logic [2:0]  b_level;
  logic        b_idle, b_ack_error;

  uart_split_16bit #(.FIFO_DEPTH(Depth), .MSB_FIRST(1'b1), .ACK_TIMEOUT(AckTo)) dut (
    .clk(clk), .rst(rst), .data_16bit(data), .data_16bit_valid(valid),
    .data_16bit_ready(ready), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(busy),
    .fifo_level(level), .idle(idle), .ack_error(ack_error)
  );

  uart_split_16bit #(.FIFO_DEPTH(Depth), .MSB_FIRST(1'b0), .ACK_TIMEOUT(AckTo)) dut_lsb (
    .clk(clk), .rst(rst), .data_16bit(b_data), .data_16bit_valid(b_valid),
    .data_16bit_ready(b_ready), .tx_data(b_tx_data), .tx_start(b_tx_start), .tx_busy(b_busy),
    .fifo_level(b_level), .idle(b_idle), .ack_error(b_ack_error)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // uart_tx model for DUT 0: busy for busy_len cycles after an accepted start.
  int   busy_len = 3;
  logic hold = 1'b0;
  int   busy_cnt = 0;
  int   ign_req = 0;
  int   ign_done = 0;
  logic u_s;
  assign busy = hold || (busy_cnt != 0);

  always begin
    @(negedge clk);
    u_s = tx_start;
    @(posedge clk);
    #1;
    if (u_s && (ign_req > ign_done)) ign_done++;
    else if (u_s) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
  end

  // uart_tx model for DUT 1, also logging its bytes.
  int         b_cnt = 0;
  logic       b_s;
  logic [7:0] log1[$];
  assign b_busy = (b_cnt != 0);

  always begin
    @(negedge clk);
    b_s = b_tx_start;
    if (b_s) log1.push_back(b_tx_data);
    @(posedge clk);
    #1;
    if (b_s) b_cnt = 3;
    else if (b_cnt > 0) b_cnt--;
  end

  // Reference model for DUT 0 plus per-cycle compare.
  logic [7:0] exp_q[$];
  logic [7:0] log0[$];
  int         pushed = 0, started = 0, bytes_idx = 0, retries_seen = 0, cyc_since = 0;
  int         model_level;
  logic       prev_start = 1'b0, ack_exp = 1'b0, saw_full = 1'b0;
  logic [7:0] last_data = 8'h00, last_byte = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      chk("ready_in_reset", int'(ready), 0);
      exp_q.delete();
      pushed = 0; started = 0; bytes_idx = 0; cyc_since = 0;
      prev_start = 1'b0; ack_exp = 1'b0; last_data = 8'h00;
    end else begin
      cyc_since++;
      if (tx_start) begin
        if (ign_done > retries_seen) begin
          retries_seen++;
          ack_exp = 1'b1;
          chk("retry_gap", cyc_since, AckTo);
          chk("retry_byte", int'(tx_data), int'(last_byte));
        end else if (exp_q.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          last_byte = exp_q.pop_front();
          chk("tx_byte", int'(tx_data), int'(last_byte));
          if (bytes_idx % 2 == 0) started++;
          bytes_idx++;
          log0.push_back(tx_data);
        end
        chk("start_back_to_back", int'(prev_start), 0);
        cyc_since = 0;
        last_data = tx_data;
      end else begin
        chk("tx_data_hold", int'(tx_data), int'(last_data));
      end
      prev_start  = tx_start;
      model_level = pushed - started;
      chk("fifo_level", int'(level), model_level);
      chk("ready", int'(ready), int'(model_level < Depth));
      chk("ack_error", int'(ack_error), int'(ack_exp));
      if (valid && ready) begin
        pushed++;
        exp_q.push_back(data[15:8]);
        exp_q.push_back(data[7:0]);
      end
      if (valid && !ready) saw_full = 1'b1;
    end
  end

  task automatic send_word(input logic [15:0] w);
    int k;
    k     = 0;
    data  = w;
    valid = 1'b1;
    forever begin
      @(negedge clk);
      if (ready) break;
      k++;
      if (k > 500) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (idle && !busy && level == 0 && !tx_start) break;
      k++;
      if (k > 2000) begin
        chk("wait_idle", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_log(input int n);
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (log0.size() >= n) break;
      k++;
      if (k > 500) begin
        chk("wait_log", 0, 1);
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int k;
    valid = 1'b0; data = '0; b_valid = 1'b0; b_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_idle", int'(idle), 1);
    chk("rst_ack_error", int'(ack_error), 0);
    chk("rst_ready", int'(ready), 1);
    @(posedge clk);
    #1;

    // 1: single word, latency and byte order
    n0 = log0.size();
    send_word(16'hA55A);
    @(negedge clk);
    chk("latency_n1", int'(tx_start), 0);
    @(negedge clk);
    chk("latency_start", int'(tx_start), 1);
    wait_idle();
    chk("t1_count", log0.size() - n0, 2);
    chk("t1_byte0", int'(log0[n0]), 8'hA5);
    chk("t1_byte1", int'(log0[n0+1]), 8'h5A);
    chk("t1_idle", int'(idle), 1);

    // 2: burst of 6 words into a depth-4 FIFO with a slow transmitter
    busy_len = 8;
    n0 = log0.size();
    for (int i = 0; i < 6; i++) send_word(16'((2 * i + 1) * 256 + 2 * i + 2));
    wait_idle();
    busy_len = 3;
    chk("t2_saw_full", int'(saw_full), 1);
    chk("t2_count", log0.size() - n0, 12);
    for (int j = 0; j < 12; j++) chk("t2_byte", int'(log0[n0+j]), j + 1);

    // 3: LSB-first instance
    b_data  = 16'h1234;
    b_valid = 1'b1;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    k = 0;
    while (log1.size() < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t3_count", log1.size(), 2);
    if (log1.size() >= 2) begin
      chk("t3_byte0", int'(log1[0]), 8'h34);
      chk("t3_byte1", int'(log1[1]), 8'h12);
    end
    @(posedge clk);
    #1;

    // 5: push+pop on the same edge at level 2, then push into a full FIFO
    n0   = log0.size();
    hold = 1'b1;
    send_word(16'h1111);
    send_word(16'h2222);
    data  = 16'h3333;
    valid = 1'b1;
    hold  = 1'b0;
    @(negedge clk);
    chk("t5_level_before", int'(level), 2);
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(negedge clk);
    chk("t5_level_pushpop", int'(level), 2);
    chk("t5_start", int'(tx_start), 1);
    wait_idle();
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) send_word(16'h4440 + 16'(i));
    data  = 16'h5555;
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_full_ready", int'(ready), 0);
      chk("t5_full_level", int'(level), 4);
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    hold  = 1'b0;
    wait_idle();
    chk("t5_count", log0.size() - n0, 14);
    chk("t5_last0", int'(log0[log0.size()-2]), 8'h44);
    chk("t5_last1", int'(log0[log0.size()-1]), 8'h44);

    // 4: transmitter ignores the first start
    n0      = log0.size();
    ign_req = ign_req + 1;
    send_word(16'hC0DE);
    wait_idle();
    chk("t4_ack_error", int'(ack_error), 1);
    chk("t4_count", log0.size() - n0, 2);
    chk("t4_byte0", int'(log0[n0]), 8'hC0);
    chk("t4_byte1", int'(log0[n0+1]), 8'hDE);

    // 6: reset between the two bytes of a word
    n0 = log0.size();
    send_word(16'hBEEF);
    wait_log(n0 + 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_tx_start", int'(tx_start), 0);
    chk("t6_level", int'(level), 0);
    chk("t6_idle", int'(idle), 1);
    chk("t6_ack_error", int'(ack_error), 0);
    @(posedge clk);
    #1;
    wait_idle();
    n0 = log0.size();
    send_word(16'h0001);
    wait_idle();
    chk("t6_count", log0.size() - n0, 2);
    chk("t6_byte0", int'(log0[n0]), 8'h00);
    chk("t6_byte1", int'(log0[n0+1]), 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
